// File: rtl/issue_buffer.sv
// issue_buffer: circular FIFO between fetch and dual-lane decode. It presents the oldest
// one or two entries show-ahead and pairs them only when the younger one is independent.
module issue_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   FetchInstr0_i,
    input  logic [DATA_WIDTH-1:0]   FetchInstr1_i,
    input  logic [1:0]              FetchCount_i,
    output logic                    FetchReady_o,
    input  logic                    Flush_i,
    input  logic                    IssueReady_i,
    output logic [DATA_WIDTH-1:0]   InstrA_o,
    output logic [DATA_WIDTH-1:0]   InstrB_o,
    output logic                    ValidA_o,
    output logic                    ValidB_o,
    output logic [$clog2(DEPTH):0]  Count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_rd, r_wr;
    logic [AW:0]           r_count;
    logic [AW-1:0]         w_rd1, w_wr1;
    logic [DATA_WIDTH-1:0] w_a, w_b;
    logic [6:0]            w_opa, w_opb;
    logic                  w_a_writes, w_raw, w_ctrl, w_mem2, w_hazard;
    logic [1:0]            w_push, w_pop;

    assign w_rd1 = r_rd + AW'(1);
    assign w_wr1 = r_wr + AW'(1);
    assign w_a   = r_mem[r_rd];
    assign w_b   = r_mem[w_rd1];
    assign w_opa = w_a[6:0];
    assign w_opb = w_b[6:0];

    // Stores and branches carry no destination even though bits [11:7] are non-zero.
    assign w_a_writes = (w_opa != 7'b0100011) && (w_opa != 7'b1100011);
    assign w_raw      = w_a_writes && (w_a[11:7] != 5'd0) &&
                        ((w_b[19:15] == w_a[11:7]) || (w_b[24:20] == w_a[11:7]));
    assign w_ctrl     = (w_opa == 7'b1100011) || (w_opa == 7'b1101111) || (w_opa == 7'b1100111);
    assign w_mem2     = ((w_opa == 7'b0000011) || (w_opa == 7'b0100011)) &&
                        ((w_opb == 7'b0000011) || (w_opb == 7'b0100011));
    assign w_hazard   = w_raw || w_ctrl || w_mem2;

    assign ValidA_o     = r_count != '0;
    assign ValidB_o     = (r_count >= (AW+1)'(2)) && !w_hazard;
    assign InstrA_o     = ValidA_o ? w_a : NOP;
    assign InstrB_o     = ValidB_o ? w_b : NOP;
    assign Count_o      = r_count;
    assign FetchReady_o = r_count <= (AW+1)'(DEPTH - 2);

    assign w_push = FetchReady_o ? (FetchCount_i[1] ? 2'd2 : {1'b0, FetchCount_i[0]}) : 2'd0;
    assign w_pop  = IssueReady_i ? ({1'b0, ValidA_o} + {1'b0, ValidB_o}) : 2'd0;

    always_ff @(posedge clk) begin
        if (!Flush_i && w_push != 2'd0) r_mem[r_wr]  <= FetchInstr0_i;
        if (!Flush_i && w_push == 2'd2) r_mem[w_wr1] <= FetchInstr1_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (Flush_i) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + AW'(w_pop);
            r_wr    <= r_wr + AW'(w_push);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_issue_buffer.sv
// tb_issue_buffer: directed checks of reset, pairing hazards, fill/drop, wrap and flush.
module tb_issue_buffer;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] f0 = '0, f1 = '0;
    logic [1:0]  fc = '0;
    logic        flush = 1'b0, iss = 1'b0;
    logic        fready, va, vb;
    logic [31:0] ia, ib;
    logic [3:0]  cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    issue_buffer #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .FetchInstr0_i(f0), .FetchInstr1_i(f1), .FetchCount_i(fc), .FetchReady_o(fready),
        .Flush_i(flush), .IssueReady_i(iss),
        .InstrA_o(ia), .InstrB_o(ib), .ValidA_o(va), .ValidB_o(vb), .Count_o(cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // independent addi: rd=(k%31)+1, rs1=0, rs2 field=0, unique upper immediate
    function automatic logic [31:0] ins(input int k);
        return 32'h13 | (32'((k % 31) + 1) << 7) | (32'(k) << 25);
    endfunction

    task automatic pair(input string tag, input logic [31:0] a, input logic [31:0] b, input logic exp_vb);
        f0 = a; f1 = b; fc = 2'd2; iss = 1'b0;
        tick();
        fc = 2'd0;
        chk({tag, "_va"}, 32'(va), 32'd1);
        chk({tag, "_vb"}, 32'(vb), 32'(exp_vb));
        chk({tag, "_a"}, ia, a);
        chk({tag, "_b"}, ib, exp_vb ? b : NOP);
        iss = 1'b1;
        tick();
        tick();
        iss = 1'b0;
        chk({tag, "_drained"}, 32'(cnt), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_va", 32'(va), 32'd0);
        chk("rst_vb", 32'(vb), 32'd0);
        chk("rst_a", ia, NOP);
        chk("rst_b", ib, NOP);
        chk("rst_fready", 32'(fready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // two independent addi pair up
        f0 = 32'h0010_0093; f1 = 32'h0020_0113; fc = 2'd2;
        tick();
        fc = 2'd0;
        chk("t2_cnt", 32'(cnt), 32'd2);
        chk("t2_va", 32'(va), 32'd1);
        chk("t2_vb", 32'(vb), 32'd1);
        chk("t2_a", ia, 32'h0010_0093);
        chk("t2_b", ib, 32'h0020_0113);
        iss = 1'b1;
        tick();
        iss = 1'b0;
        chk("t2_pop_cnt", 32'(cnt), 32'd0);
        chk("t2_pop_va", 32'(va), 32'd0);

        // RAW on x1
        f0 = 32'h0010_0093; f1 = 32'h0010_81B3; fc = 2'd2;
        tick();
        fc = 2'd0;
        chk("t3_va", 32'(va), 32'd1);
        chk("t3_vb", 32'(vb), 32'd0);
        chk("t3_b", ib, NOP);
        iss = 1'b1;
        tick();
        chk("t3_cnt1", 32'(cnt), 32'd1);
        chk("t3_a", ia, 32'h0010_81B3);
        chk("t3_vb2", 32'(vb), 32'd0);
        tick();
        iss = 1'b0;
        chk("t3_cnt0", 32'(cnt), 32'd0);

        pair("t4_lwsw", 32'h0000_A083, 32'h0020_A023, 1'b0);
        pair("t4_mem2", 32'h0003_2283, 32'h0074_2023, 1'b0);
        pair("t4_lwalu", 32'h0003_2283, 32'h0020_0113, 1'b1);
        pair("t4_beq", 32'h0000_0063, 32'h0020_0113, 1'b0);

        // fill to DEPTH, then a dropped push
        for (int i = 0; i < 4; i++) begin
            f0 = ins(2*i); f1 = ins(2*i+1); fc = 2'd2;
            tick();
            chk("t5_cnt", 32'(cnt), 32'(2*i+2));
            chk("t5_fready", 32'(fready), (i == 3) ? 32'd0 : 32'd1);
        end
        f0 = ins(20); f1 = ins(21);
        tick();
        fc = 2'd0;
        chk("t5_drop_cnt", 32'(cnt), 32'd8);
        iss = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_a", ia, ins(2*i));
            chk("t5_b", ib, ins(2*i+1));
            tick();
        end
        iss = 1'b0;
        chk("t5_empty", 32'(cnt), 32'd0);

        // streaming push 2 / pop 2 across pointer wrap
        f0 = ins(32); f1 = ins(33); fc = 2'd2; iss = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) begin
            chk("t6_cnt", 32'(cnt), 32'd2);
            chk("t6_a", ia, ins(32 + 2*(i-1)));
            chk("t6_b", ib, ins(33 + 2*(i-1)));
            f0 = ins(32 + 2*i); f1 = ins(33 + 2*i);
            tick();
        end
        chk("t6_last_a", ia, ins(56));
        flush = 1'b1;
        tick();
        flush = 1'b0; fc = 2'd0; iss = 1'b0;
        chk("t6_flush_cnt", 32'(cnt), 32'd0);
        chk("t6_flush_va", 32'(va), 32'd0);
        chk("t6_flush_vb", 32'(vb), 32'd0);

        // asynchronous reset with 5 entries held
        f0 = ins(1); f1 = ins(2); fc = 2'd2;
        tick();
        tick();
        fc = 2'd1;
        tick();
        fc = 2'd0;
        chk("t1_pre_cnt", 32'(cnt), 32'd5);
        rst = 1'b0;
        #1;
        chk("t1_cnt", 32'(cnt), 32'd0);
        chk("t1_va", 32'(va), 32'd0);
        chk("t1_vb", 32'(vb), 32'd0);
        chk("t1_a", ia, NOP);
        chk("t1_fready", 32'(fready), 32'd1);
        #1;
        rst = 1'b1;
        tick();
        chk("t1_post_cnt", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
